fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the instruction, PC and data width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port StallD  input  1  decode stage cannot accept a new instruction; hold the IF/ID register.
REQ-006 SHALL have port FlushD  input  1  replace the IF/ID register contents with a bubble.
REQ-007 SHALL have port PCSrcE  input  1  redirect request from execute (taken branch/jump).
REQ-008 SHALL have port PCTargetE  input  DATA_WIDTH  redirect target address.
REQ-009 SHALL have port IMemReq  output  1  instruction-memory request valid.
REQ-010 SHALL have port IMemAddr  output  DATA_WIDTH  request address; equals PCF.
REQ-011 SHALL have port IMemGnt  input  1  memory accepted the request this cycle.
REQ-012 SHALL have port IMemValid  input  1  read data valid (at least 1 cycle after grant).
REQ-013 SHALL have port IMemRdata  input  DATA_WIDTH  fetched instruction word.
REQ-014 SHALL have ports InstrD, PCD, PCPlus4D  output  DATA_WIDTH each, and ValidD  output  1, forming the IF/ID register that feeds decode and immediate extension.

Function
REQ-015 SHALL keep at most one memory request outstanding, tracked by states FETCH, WAIT, DROP, HOLD.
REQ-016 SHALL, in FETCH: drive IMemReq=1; on IMemGnt go WAIT; on PCSrcE without grant set PCF<=PCTargetE and stay in FETCH; on PCSrcE with grant set PCF<=PCTargetE and go DROP.
REQ-017 SHALL, in WAIT with IMemValid and no PCSrcE: load IF/ID if StallD=0 (InstrD<=IMemRdata, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1), set PCF<=PCF+4, go FETCH; with StallD=1 store the word in a one-entry hold buffer and go HOLD.
REQ-018 SHALL, in WAIT, handle PCSrcE as follows: with IMemValid, discard the data, set PCF<=PCTargetE and go FETCH; without IMemValid, set PCF<=PCTargetE and go DROP.
REQ-019 SHALL, in DROP: drive IMemReq=0; on IMemValid discard the data and go FETCH; a further PCSrcE updates PCF only.
REQ-020 SHALL, in HOLD: drive IMemReq=0; when StallD=0 load IF/ID from the buffer, set PCF<=PCF+4 and go FETCH; PCSrcE discards the buffer, sets PCF<=PCTargetE and goes FETCH.
REQ-021 SHALL give FlushD priority over any load: next cycle ValidD=0 and InstrD=32'h0000_0013 (NOP); a concurrent load is lost and the stage behaves as for PCSrcE.
REQ-022 SHALL hold all IF/ID outputs unchanged while StallD=1 and FlushD=0.
REQ-023 SHALL, when StallD=0, FlushD=0 and no word is delivered, load a bubble (ValidD=0, InstrD=NOP, PCD and PCPlus4D unchanged).
REQ-024 SHALL compute PCF+4 modulo 2^DATA_WIDTH, wrapping from 32'hFFFF_FFFC to 0.
REQ-025 SHALL drive IMemAddr=PCF combinationally; IMemAddr is stable while IMemReq=1 and IMemGnt=0.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set state=FETCH, PCF=RESET_PC, ValidD=0, InstrD=NOP, PCD=0, PCPlus4D=0, and clear the hold buffer.
REQ-027 SHALL force IMemReq=0 during any cycle with rst=1; reset mid-transaction ignores any later response belonging to the aborted request until the first post-reset grant.

Configuration
REQ-028 SHALL, when FETCH_PERF_CNT_EN is defined, add output FetchCnt [31:0], reset 0, incremented by 1 on every IF/ID load with ValidD=1 and wrapping at 2^32.
REQ-029 SHALL, when FETCH_PERF_CNT_EN is undefined, have no FetchCnt port and no counter logic, with all other behaviour identical.

Verification
REQ-030 SHALL cover: reset, then grant and valid each with 1-cycle latency and words 0x00500093, 0x00100113 -> ValidD=1 with PCD=0 then PCD=4, PCPlus4D=4 then 8.
REQ-031 SHALL cover: StallD=1 when 0x00208193 returns -> HOLD with IMemReq=0; StallD=0 two cycles later -> InstrD=0x00208193 and the next request at PCF+4.
REQ-032 SHALL cover: PCSrcE=1 with PCTargetE=0x100 while in WAIT -> the in-flight response is dropped and the next IMemAddr=0x100.
REQ-033 SHALL cover: FlushD=1 in the same cycle a word is delivered -> ValidD=0, InstrD=0x00000013.
REQ-034 SHALL cover: PCF=0xFFFFFFFC with a delivered word -> PCPlus4D=0 and the next IMemAddr=0.
REQ-035 SHALL cover: with FETCH_PERF_CNT_EN defined, 5 valid loads plus 2 bubbles -> FetchCnt=5.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request FSM and IF/ID register.
// Optional retired-fetch counter (FetchCnt) is built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = DATA_WIDTH'(32'h0000_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  StallD,
  input  logic                  FlushD,
  input  logic                  PCSrcE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  output logic                  IMemReq,
  output logic [DATA_WIDTH-1:0] IMemAddr,
  input  logic                  IMemGnt,
  input  logic                  IMemValid,
  input  logic [DATA_WIDTH-1:0] IMemRdata,
  output logic [DATA_WIDTH-1:0] InstrD,
  output logic [DATA_WIDTH-1:0] PCD,
  output logic [DATA_WIDTH-1:0] PCPlus4D,
  output logic                  ValidD
`ifdef FETCH_PERF_CNT_EN
  , output logic [31:0]         FetchCnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  typedef enum logic [1:0] {FETCH, WAIT, DROP, HOLD} state_t;
  typedef enum logic [1:0] {PC_KEEP, PC_PLUS4, PC_TARGET} pc_sel_t;

  state_t                  state_q, state_d;
  pc_sel_t                 pc_sel;
  logic [DATA_WIDTH-1:0]   pcf_q;
  logic [DATA_WIDTH-1:0]   pcf_plus4;
  logic [DATA_WIDTH-1:0]   hold_q;
  logic                    load_mem;
  logic                    load_buf;
  logic                    cap_buf;

  assign pcf_plus4 = pcf_q + DATA_WIDTH'(4);
  assign IMemAddr  = pcf_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state, request strobe and datapath controls
  always_comb begin
    state_d  = state_q;
    IMemReq  = 1'b0;
    pc_sel   = PC_KEEP;
    load_mem = 1'b0;
    load_buf = 1'b0;
    cap_buf  = 1'b0;
    unique case (state_q)
      FETCH: begin
        IMemReq = !rst;
        if (PCSrcE) pc_sel = PC_TARGET;
        if (IMemGnt) state_d = PCSrcE ? DROP : WAIT;
      end
      WAIT: begin
        if (PCSrcE) begin
          pc_sel  = PC_TARGET;
          state_d = IMemValid ? FETCH : DROP;
        end else if (IMemValid) begin
          if (StallD) begin
            cap_buf = 1'b1;
            state_d = HOLD;
          end else if (FlushD) begin
            // Flushed delivery is dropped and treated like a redirect
            pc_sel  = PC_TARGET;
            state_d = FETCH;
          end else begin
            load_mem = 1'b1;
            pc_sel   = PC_PLUS4;
            state_d  = FETCH;
          end
        end
      end
      DROP: begin
        if (PCSrcE) pc_sel = PC_TARGET;
        if (IMemValid) state_d = FETCH;
      end
      HOLD: begin
        if (PCSrcE || (!StallD && FlushD)) begin
          pc_sel  = PC_TARGET;
          state_d = FETCH;
        end else if (!StallD) begin
          load_buf = 1'b1;
          pc_sel   = PC_PLUS4;
          state_d  = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Fetch PC
  always_ff @(posedge clk) begin
    if (rst) begin
      pcf_q <= RESET_PC;
    end else begin
      unique case (pc_sel)
        PC_PLUS4:  pcf_q <= pcf_plus4;
        PC_TARGET: pcf_q <= PCTargetE;
        default:   pcf_q <= pcf_q;
      endcase
    end
  end

  // One-entry buffer for a word returned while decode is stalled
  always_ff @(posedge clk) begin
    if (rst)          hold_q <= '0;
    else if (cap_buf) hold_q <= IMemRdata;
  end

  // IF/ID register: flush beats stall, stall beats load, otherwise bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      InstrD   <= NOP;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (load_mem || load_buf) begin
        InstrD   <= load_mem ? IMemRdata : hold_q;
        PCD      <= pcf_q;
        PCPlus4D <= pcf_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count valid IF/ID loads
  always_ff @(posedge clk) begin
    if (rst)                       FetchCnt <= '0;
    else if (load_mem || load_buf) FetchCnt <= FetchCnt + 32'(1);
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; checks FetchCnt when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemGnt, IMemValid;
  logic [31:0] IMemRdata;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk       (clk),
    .rst       (rst),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemGnt   (IMemGnt),
    .IMemValid (IMemValid),
    .IMemRdata (IMemRdata),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt(FetchCnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] words [5];

  initial begin
    words = '{32'h0000_0293, 32'h0010_0313, 32'h0020_0393, 32'h0030_0413, 32'h0040_0493};
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = '0;
    IMemGnt = 1'b0; IMemValid = 1'b0; IMemRdata = '0;
    tick(); tick();

    // Reset state
    check("rst_req",    32'(IMemReq), 32'd0);
    check("rst_valid",  32'(ValidD),  32'd0);
    check("rst_instr",  InstrD,       NOP);
    check("rst_pcd",    PCD,          32'h0);
    check("rst_pcp4",   PCPlus4D,     32'h0);
    check("rst_addr",   IMemAddr,     32'h0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_cnt",    FetchCnt,     32'd0);
`endif
    rst = 1'b0;
    #1;
    check("fetch_req",  32'(IMemReq), 32'd1);

    // Two back-to-back fetches, 1-cycle grant and data latency
    IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = 32'h0050_0093;
    check("wait_req",   32'(IMemReq), 32'd0);
    tick();
    check("f1_valid",   32'(ValidD),  32'd1);
    check("f1_instr",   InstrD,       32'h0050_0093);
    check("f1_pcd",     PCD,          32'h0);
    check("f1_pcp4",    PCPlus4D,     32'h4);
    check("f1_addr",    IMemAddr,     32'h4);
    IMemValid = 1'b0; IMemGnt = 1'b1; tick();
    check("bub_valid",  32'(ValidD),  32'd0);
    check("bub_instr",  InstrD,       NOP);
    check("bub_pcd",    PCD,          32'h0);
    IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = 32'h0010_0113; tick();
    check("f2_valid",   32'(ValidD),  32'd1);
    check("f2_instr",   InstrD,       32'h0010_0113);
    check("f2_pcd",     PCD,          32'h4);
    check("f2_pcp4",    PCPlus4D,     32'h8);

    // Stall when the word returns: held in buffer, released two cycles later
    IMemValid = 1'b0; IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = 32'h0020_8193; StallD = 1'b1; tick();
    check("hold_req",   32'(IMemReq), 32'd0);
    check("hold_valid", 32'(ValidD),  32'd0);
    IMemValid = 1'b0; tick();
    check("hold_req2",  32'(IMemReq), 32'd0);
    check("hold_addr",  IMemAddr,     32'h8);
    StallD = 1'b0; tick();
    check("rel_valid",  32'(ValidD),  32'd1);
    check("rel_instr",  InstrD,       32'h0020_8193);
    check("rel_pcd",    PCD,          32'h8);
    check("rel_addr",   IMemAddr,     32'hC);
    check("rel_req",    32'(IMemReq), 32'd1);

    // Redirect while waiting: in-flight response dropped
    IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100; tick();
    check("drop_req",   32'(IMemReq), 32'd0);
    check("drop_addr",  IMemAddr,     32'h100);
    PCSrcE = 1'b0; IMemValid = 1'b1; IMemRdata = 32'hDEAD_BEEF; tick();
    check("drop_valid", 32'(ValidD),  32'd0);
    check("drop_instr", InstrD,       NOP);
    check("drop_nreq",  32'(IMemReq), 32'd1);
    check("drop_naddr", IMemAddr,     32'h100);

    // Flush on the cycle a word is delivered
    IMemValid = 1'b0; IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = 32'h0000_0533; FlushD = 1'b1; tick();
    check("flush_valid", 32'(ValidD), 32'd0);
    check("flush_instr", InstrD,      NOP);
    check("flush_req",  32'(IMemReq), 32'd1);
    FlushD = 1'b0; IMemValid = 1'b0;

    // Redirect in FETCH without grant, then PC wrap
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC; tick();
    PCSrcE = 1'b0;
    check("redir_addr", IMemAddr,     32'hFFFF_FFFC);
    check("redir_req",  32'(IMemReq), 32'd1);
    IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = 32'h00A0_0513; tick();
    check("wrap_valid", 32'(ValidD),  32'd1);
    check("wrap_pcd",   PCD,          32'hFFFF_FFFC);
    check("wrap_pcp4",  PCPlus4D,     32'h0);
    check("wrap_addr",  IMemAddr,     32'h0);
    IMemValid = 1'b0; tick();

    // Reset mid-transaction: request forced low, stale response ignored
    IMemGnt = 1'b1; tick();
    IMemGnt = 1'b0; rst = 1'b1; tick();
    check("mrst_req",   32'(IMemReq), 32'd0);
    rst = 1'b0; IMemValid = 1'b1; IMemRdata = 32'hBAD0_0BAD; tick();
    check("mrst_valid", 32'(ValidD),  32'd0);
    check("mrst_req1",  32'(IMemReq), 32'd1);
    check("mrst_addr",  IMemAddr,     32'h0);
    IMemValid = 1'b0;

    // Five valid loads separated by bubbles
    for (int i = 0; i < 5; i++) begin
      IMemGnt = 1'b1; tick();
      IMemGnt = 1'b0; IMemValid = 1'b1; IMemRdata = words[i]; tick();
      IMemValid = 1'b0;
      check("seq_instr", InstrD, words[i]);
      check("seq_pcd",   PCD,    32'(4 * i));
    end
    tick();
`ifdef FETCH_PERF_CNT_EN
    check("cnt_5",      FetchCnt,     32'd5);
`endif

    // Redirect in FETCH coincident with grant goes through DROP
    IMemGnt = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h40; tick();
    IMemGnt = 1'b0; PCSrcE = 1'b0;
    check("gdrop_req",  32'(IMemReq), 32'd0);
    check("gdrop_addr", IMemAddr,     32'h40);
    IMemValid = 1'b1; IMemRdata = 32'h1111_1111; tick();
    IMemValid = 1'b0;
    check("gdrop_valid", 32'(ValidD), 32'd0);
    check("gdrop_nreq", 32'(IMemReq), 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("cnt_hold",   FetchCnt,     32'd5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
